// File: rtl/calc_pkg.sv
// Shared definitions for the keypad operand-entry block: key codes, FSM
// state encoding and the elaboration-time width check helper.
package calc_pkg;

  localparam logic [3:0] KEY_BACKSPACE = 4'd10;
  localparam logic [3:0] KEY_CLEAR     = 4'd11;
  localparam logic [3:0] KEY_NEXT      = 4'd12;
  localparam logic [3:0] KEY_ENTER     = 4'd13;
  localparam logic [3:0] KEY_SEL_FIRST = 4'd14;
  localparam logic [3:0] KEY_SEL_LAST  = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Largest value representable with the given number of decimal digits.
  function automatic longint unsigned max_bcd_value(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

  // True when every DIGITS-digit decimal number fits in WIDTH bits.
  function automatic bit width_fits(input int digits, input int width);
    if (width >= 64) return 1'b1;
    return max_bcd_value(digits) < (64'd1 << width);
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter: one nibble per cycle, MSB nibble first,
// acc = acc*10 + nibble. Result is presented combinationally on the cycle
// whose closing edge consumes the last nibble (result_valid_o high).
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DIGITS*4-1:0]   bcd_i,
  output logic                  busy_o,
  output logic [WIDTH-1:0]      result_o,
  output logic                  result_valid_o
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  logic [DIGITS*4-1:0] sh_q,   sh_d;
  logic [WIDTH-1:0]    acc_q,  acc_d;
  logic [CNT_W-1:0]    cnt_q,  cnt_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    acc_next;

  // Multiply-accumulate of the current top nibble.
  always_comb begin
    acc_next = (acc_q << 3) + (acc_q << 1) + WIDTH'(sh_q[DIGITS*4-1 -: 4]);
  end

  // Load on start, otherwise consume one nibble per busy cycle.
  always_comb begin
    sh_d   = sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      sh_d   = bcd_i;
      acc_d  = '0;
      cnt_d  = CNT_W'(DIGITS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_next;
      sh_d  = sh_q << 4;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  // Converter state registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_o       = acc_next;
  assign result_valid_o = busy_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry: edge-detected key events edit BCD operands, each edit
// triggers a DIGITS-cycle conversion that refreshes the binary operand.
module operand_entry
  import calc_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int NUM_OPERANDS = 2,
  parameter int WIDTH        = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      key_code,
  input  logic                            key_valid,
  output logic [NUM_OPERANDS*WIDTH-1:0]   operands,
  output logic [NUM_OPERANDS-1:0]         sel_onehot,
  output logic [$clog2(DIGITS+1)-1:0]     digit_count,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int IW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int BW = DIGITS * 4;

  generate
    if (!width_fits(DIGITS, WIDTH)) begin : g_width_chk
      $error("operand_entry: WIDTH too small for DIGITS decimal digits");
    end
  endgenerate

  logic [BW-1:0]    bcd_q [NUM_OPERANDS];
  logic [BW-1:0]    bcd_d [NUM_OPERANDS];
  logic [CW-1:0]    cnt_q [NUM_OPERANDS];
  logic [CW-1:0]    cnt_d [NUM_OPERANDS];
  logic [WIDTH-1:0] bin_q [NUM_OPERANDS];
  logic [WIDTH-1:0] bin_d [NUM_OPERANDS];
  logic [IW-1:0]    idx_q, idx_d;
  logic             key_prev_q;
  logic             done_q, done_d;
  logic             err_q, err_d;
  state_t           state_q, state_d;

  logic             key_evt;
  logic             conv_start;
  logic [BW-1:0]    conv_bcd;
  logic             conv_busy;
  logic [WIDTH-1:0] conv_result;
  logic             conv_valid;

  assign key_evt = key_valid && !key_prev_q;

  bcd_to_bin #(
    .DIGITS (DIGITS),
    .WIDTH  (WIDTH)
  ) u_conv (
    .clk            (clk),
    .rst            (rst),
    .start_i        (conv_start),
    .bcd_i          (conv_bcd),
    .busy_o         (conv_busy),
    .result_o       (conv_result),
    .result_valid_o (conv_valid)
  );

  // Key decode and operand editing; only the active operand is touched.
  always_comb begin
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    conv_start = 1'b0;
    if (conv_valid) bin_d[idx_q] = conv_result;
    if (key_evt) begin
      if (state_q == ST_CONV) begin
        err_d = 1'b1;
      end else begin
        case (key_code)
          KEY_BACKSPACE: begin
            if (cnt_q[idx_q] == '0) begin
              err_d = 1'b1;
            end else begin
              bcd_d[idx_q] = bcd_q[idx_q] >> 4;
              cnt_d[idx_q] = cnt_q[idx_q] - CW'(1);
              conv_start   = 1'b1;
            end
          end
          KEY_CLEAR: begin
            bcd_d[idx_q] = '0;
            cnt_d[idx_q] = '0;
            bin_d[idx_q] = '0;
          end
          KEY_NEXT: begin
            idx_d = (idx_q == IW'(NUM_OPERANDS - 1)) ? '0 : idx_q + IW'(1);
          end
          KEY_ENTER: begin
            done_d = 1'b1;
          end
          KEY_SEL_FIRST: begin
            idx_d    = '0;
            bcd_d[0] = '0;
            cnt_d[0] = '0;
            bin_d[0] = '0;
          end
          KEY_SEL_LAST: begin
            idx_d                   = IW'(NUM_OPERANDS - 1);
            bcd_d[NUM_OPERANDS - 1] = '0;
            cnt_d[NUM_OPERANDS - 1] = '0;
            bin_d[NUM_OPERANDS - 1] = '0;
          end
          default: begin
            if (cnt_q[idx_q] == CW'(DIGITS)) begin
              err_d = 1'b1;
            end else begin
              bcd_d[idx_q] = (bcd_q[idx_q] << 4) | BW'(key_code);
              cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
              conv_start   = 1'b1;
            end
          end
        endcase
      end
    end
    conv_bcd = bcd_d[idx_q];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: an accepted BCD edit starts a conversion, its last nibble ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (conv_start) state_d = ST_CONV;
      ST_CONV: if (conv_valid || !conv_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == ST_CONV);
  end

  // Operand storage, selection, edge detector and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        bcd_q[i] <= '0;
        cnt_q[i] <= '0;
        bin_q[i] <= '0;
      end
      idx_q      <= '0;
      key_prev_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        bcd_q[i] <= bcd_d[i];
        cnt_q[i] <= cnt_d[i];
        bin_q[i] <= bin_d[i];
      end
      idx_q      <= idx_d;
      key_prev_q <= key_valid;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Flatten operands and decode the active index for the LEDs.
  always_comb begin
    operands   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_OPERANDS; i++) begin
      operands[i*WIDTH +: WIDTH] = bin_q[i];
      sel_onehot[i]              = (idx_q == IW'(i));
    end
  end

  assign digit_count = cnt_q[idx_q];
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry (DIGITS=4, NUM_OPERANDS=2, WIDTH=32).
module tb_operand_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [63:0] operands;
  logic [1:0]  sel_onehot;
  logic [2:0]  digit_count;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  operand_entry #(
    .DIGITS       (4),
    .NUM_OPERANDS (2),
    .WIDTH        (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .operands    (operands),
    .sel_onehot  (sel_onehot),
    .digit_count (digit_count),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One key press: event edge, release, then wait out any conversion.
  task automatic press(input logic [3:0] c, input string tag,
                       input logic exp_err, input logic exp_done, input logic exp_busy);
    int n;
    key_code  = c;
    key_valid = 1'b1;
    tick();
    chk({tag, "_err"},  64'(err),  64'(exp_err));
    chk({tag, "_done"}, 64'(done), 64'(exp_done));
    chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    key_valid = 1'b0;
    tick();
    chk({tag, "_pulse"}, 64'({done, err}), 64'd0);
    if (exp_busy) begin
      n = 0;
      while (busy && n < 20) begin
        tick();
        n++;
      end
      chk({tag, "_convlen"}, 64'(n), 64'd3);
    end
  endtask

  function automatic logic [63:0] ops(input logic [31:0] op1, input logic [31:0] op0);
    return {op1, op0};
  endfunction

  initial begin
    int n;
    int errs_seen;
    rst       = 1'b1;
    key_code  = 4'd0;
    key_valid = 1'b0;
    tick();
    tick();
    chk("rst_operands", operands, 64'd0);
    chk("rst_sel",      64'(sel_onehot), 64'd1);
    chk("rst_count",    64'(digit_count), 64'd0);
    chk("rst_status",   64'({busy, done, err}), 64'd0);
    rst = 1'b0;
    tick();

    // 1,2,3,4 then a fifth digit is rejected
    press(4'd1, "d1", 1'b0, 1'b0, 1'b1);
    chk("d1_val", operands, ops(0, 1));
    press(4'd2, "d2", 1'b0, 1'b0, 1'b1);
    chk("d2_val", operands, ops(0, 12));
    press(4'd3, "d3", 1'b0, 1'b0, 1'b1);
    chk("d3_val", operands, ops(0, 123));
    press(4'd4, "d4", 1'b0, 1'b0, 1'b1);
    chk("d4_val", operands, ops(0, 1234));
    chk("d4_count", 64'(digit_count), 64'd4);
    press(4'd5, "d5_full", 1'b1, 1'b0, 1'b0);
    chk("d5_val", operands, ops(0, 1234));
    chk("d5_count", 64'(digit_count), 64'd4);

    // CLEAR, then 9,8,BACKSPACE x3
    press(4'd11, "clr", 1'b0, 1'b0, 1'b0);
    chk("clr_val", operands, ops(0, 0));
    chk("clr_count", 64'(digit_count), 64'd0);
    press(4'd9, "d9", 1'b0, 1'b0, 1'b1);
    press(4'd8, "d8", 1'b0, 1'b0, 1'b1);
    chk("d98_val", operands, ops(0, 98));
    press(4'd10, "bs1", 1'b0, 1'b0, 1'b1);
    chk("bs1_val", operands, ops(0, 9));
    chk("bs1_count", 64'(digit_count), 64'd1);
    press(4'd10, "bs2", 1'b0, 1'b0, 1'b1);
    chk("bs2_val", operands, ops(0, 0));
    chk("bs2_count", 64'(digit_count), 64'd0);
    press(4'd10, "bs3_empty", 1'b1, 1'b0, 1'b0);
    chk("bs3_val", operands, ops(0, 0));

    // 4,2,NEXT,7,ENTER
    press(4'd4, "e4", 1'b0, 1'b0, 1'b1);
    press(4'd2, "e2", 1'b0, 1'b0, 1'b1);
    chk("e42_val", operands, ops(0, 42));
    press(4'd12, "next1", 1'b0, 1'b0, 1'b0);
    chk("next1_sel", 64'(sel_onehot), 64'd2);
    chk("next1_count", 64'(digit_count), 64'd0);
    press(4'd7, "e7", 1'b0, 1'b0, 1'b1);
    chk("e7_val", operands, ops(7, 42));
    press(4'd13, "enter", 1'b0, 1'b1, 1'b0);
    chk("enter_val", operands, ops(7, 42));
    chk("enter_sel", 64'(sel_onehot), 64'd2);

    // On operand1: CLEAR, 1,2, SEL_LAST, NEXT wraps
    press(4'd11, "clr1", 1'b0, 1'b0, 1'b0);
    chk("clr1_val", operands, ops(0, 42));
    press(4'd1, "f1", 1'b0, 1'b0, 1'b1);
    press(4'd2, "f2", 1'b0, 1'b0, 1'b1);
    chk("f12_val", operands, ops(12, 42));
    chk("f12_count", 64'(digit_count), 64'd2);
    press(4'd15, "sel_last", 1'b0, 1'b0, 1'b0);
    chk("sel_last_val", operands, ops(0, 42));
    chk("sel_last_count", 64'(digit_count), 64'd0);
    chk("sel_last_sel", 64'(sel_onehot), 64'd2);
    press(4'd12, "next_wrap", 1'b0, 1'b0, 1'b0);
    chk("wrap_sel", 64'(sel_onehot), 64'd1);
    chk("wrap_count", 64'(digit_count), 64'd2);

    // key_valid held 20 cycles gives exactly one digit
    press(4'd14, "sel_first", 1'b0, 1'b0, 1'b0);
    chk("sel_first_val", operands, ops(0, 0));
    key_code  = 4'd5;
    key_valid = 1'b1;
    errs_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (err) errs_seen++;
    end
    key_valid = 1'b0;
    tick();
    chk("hold_errs", 64'(errs_seen), 64'd0);
    chk("hold_val", operands, ops(0, 5));
    chk("hold_count", 64'(digit_count), 64'd1);
    chk("hold_busy", 64'(busy), 64'd0);

    // Second edge while busy is rejected
    press(4'd14, "sel_first2", 1'b0, 1'b0, 1'b0);
    key_code  = 4'd5;
    key_valid = 1'b1;
    tick();
    chk("gl_busy", 64'(busy), 64'd1);
    key_valid = 1'b0;
    tick();
    key_valid = 1'b1;
    tick();
    chk("gl_err", 64'(err), 64'd1);
    errs_seen = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (err) errs_seen++;
    end
    key_valid = 1'b0;
    tick();
    chk("gl_err_once", 64'(errs_seen), 64'd0);
    chk("gl_val", operands, ops(0, 5));
    chk("gl_count", 64'(digit_count), 64'd1);

    // Reset in the middle of a conversion, key held across release
    press(4'd14, "sel_first3", 1'b0, 1'b0, 1'b0);
    press(4'd3, "r3", 1'b0, 1'b0, 1'b1);
    chk("r3_val", operands, ops(0, 3));
    key_code  = 4'd3;
    key_valid = 1'b1;
    tick();
    chk("r33_busy", 64'(busy), 64'd1);
    chk("r33_count", 64'(digit_count), 64'd2);
    key_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_operands", operands, 64'd0);
    chk("arst_sel",      64'(sel_onehot), 64'd1);
    chk("arst_count",    64'(digit_count), 64'd0);
    chk("arst_status",   64'({busy, done, err}), 64'd0);
    key_code  = 4'd6;
    key_valid = 1'b1;
    tick();
    tick();
    chk("arst_hold_val", operands, 64'd0);
    rst = 1'b0;
    tick();
    chk("rel_busy", 64'(busy), 64'd1);
    chk("rel_count", 64'(digit_count), 64'd1);
    key_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("rel_convlen", 64'(n), 64'd4);
    chk("rel_val", operands, ops(0, 6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
